// File: rtl/mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_ctrl_pkg
// Description : Shared definitions for the programmable mux select sequencer:
//               default sizes, the row-end index helper and the reference
//               select patterns for mode 0 and mode 1.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_ctrl_pkg;

    localparam int N_MODE_DEF    = 4;
    localparam int SEQ_DEPTH_DEF = 16;

    // Reference select patterns; the last index is the final valid entry.
    localparam int c_mode0_len       = 12;
    localparam int c_mode0_pat [12]  = '{0, 1, 2, 3, 4, 5, 1, 0, 3, 2, 5, 4};
    localparam int c_mode0_last      = 11;
    localparam int c_mode1_len       = 3;
    localparam int c_mode1_pat [3]   = '{0, 3, 4};
    localparam int c_mode1_last      = 2;

    // Index of the last output column of a row. A kernel wider than the
    // padded picture would give a negative index; clamp it to zero so the
    // row counter then wraps on every update.
    function automatic logic [31:0] row_last_f(
        input logic [31:0] pic,
        input logic [31:0] pad,
        input logic [31:0] kern
    );
        logic [31:0] span;
        span = pic + (pad << 1);
        return (span < kern) ? 32'd0 : (span - kern);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : mux_seq_table
// Description : Per-mode select table and last-index register file. Entry
//               and last-index writes may occur in the same cycle. Reads are
//               combinational, so a write is visible from the next cycle.
// Revision    : 1.0 - initial release
// Ports       : SYS_CLK, SYS_RST       clock, sync active-high reset
//               wr_tab_en/wr_len_en    entry / last-index write strobes
//               wr_mode, wr_addr       write target mode and entry index
//               wr_sel, wr_last        entry data, last-index data
//               rd_mode, rd_ptr        read mode and entry index
//               rd_sel, rd_last        selected entry, last index of rd_mode
// ============================================================================
module mux_seq_table #(
    parameter int N_MODE    = 4,
    parameter int SEQ_DEPTH = 16,
    parameter int SEL_W     = 3,
    parameter int PTR_W     = 4,
    parameter int MODE_W    = 2
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              wr_tab_en,
    input  logic              wr_len_en,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [PTR_W-1:0]  wr_last,
    input  logic [MODE_W-1:0] rd_mode,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [SEL_W-1:0]  rd_sel,
    output logic [PTR_W-1:0]  rd_last
);

    logic [SEL_W-1:0] r_tab  [N_MODE][SEQ_DEPTH];
    logic [PTR_W-1:0] r_last [N_MODE];

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            for (int m = 0; m < N_MODE; m++) begin
                r_last[m] <= '0;
                for (int e = 0; e < SEQ_DEPTH; e++) begin
                    r_tab[m][e] <= '0;
                end
            end
        end else begin
            if (wr_tab_en) begin
                r_tab[wr_mode][wr_addr] <= wr_sel;
            end
            if (wr_len_en) begin
                r_last[wr_mode] <= wr_last;
            end
        end
    end

    assign rd_sel  = r_tab[rd_mode][rd_ptr];
    assign rd_last = r_last[rd_mode];

endmodule
`default_nettype wire

// File: rtl/mux_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : mux_ctrl_seq
// Description : Programmable select sequencer for the input-buffer N:1 mux.
//               Steps a per-mode pointer through a run-time loaded select
//               table on each ctrl_update_i, with a row-end counter that can
//               restart the pointer per mode.
// Revision    : 1.0 - initial release
// Ports       : SYS_CLK, SYS_RST       clock, sync active-high reset
//               mode_i                 one-hot mode, lowest bit wins, 0 = idle
//               ctrl_update_i          advance one select step
//               ctrl_reset_i           restart pointer and row counter
//               pic_size_i, padding_i, kernel_i  row geometry
//               cfg_we_i, cfg_len_we_i entry / last-index writes
//               cfg_mode_i, cfg_addr_i, cfg_data_i  write target and data
//               row_rst_en_i           per-mode pointer restart at row end
//               ctrl_mux_o             registered mux select
//               row_end_o, seq_wrap_o  one-cycle event pulses
//               cfg_err_o              sticky illegal-write flag
// ============================================================================
module mux_ctrl_seq
    import mux_ctrl_pkg::*;
#(
    parameter int N_SEL     = 6,
    parameter int SEQ_DEPTH = SEQ_DEPTH_DEF,
    parameter int N_MODE    = N_MODE_DEF,
    parameter int PIC_W     = 6,
    localparam int SEL_W    = (N_SEL > 1) ? $clog2(N_SEL) : 1,
    localparam int PTR_W    = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1,
    localparam int MODE_W   = (N_MODE > 1) ? $clog2(N_MODE) : 1,
    localparam int DATA_W   = (SEL_W > PTR_W) ? SEL_W : PTR_W
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic [N_MODE-1:0] mode_i,
    input  logic              ctrl_update_i,
    input  logic              ctrl_reset_i,
    input  logic [PIC_W-1:0]  pic_size_i,
    input  logic [1:0]        padding_i,
    input  logic [3:0]        kernel_i,
    input  logic              cfg_we_i,
    input  logic              cfg_len_we_i,
    input  logic [MODE_W-1:0] cfg_mode_i,
    input  logic [PTR_W-1:0]  cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic [N_MODE-1:0] row_rst_en_i,
    output logic [SEL_W-1:0]  ctrl_mux_o,
    output logic              row_end_o,
    output logic              seq_wrap_o,
    output logic              cfg_err_o
);

    localparam int RC_W = PIC_W + 2;

    logic [PTR_W-1:0]  r_ptr;
    logic [RC_W-1:0]   r_rcnt;
    logic [MODE_W-1:0] r_am;
    logic              r_mode_vld;
    logic [SEL_W-1:0]  r_mux;
    logic              r_row_end;
    logic              r_seq_wrap;
    logic              r_err;

    logic [MODE_W-1:0] w_am;
    logic              w_mode_vld;
    logic              w_mode_chg;
    logic [RC_W-1:0]   w_row_last;
    logic              w_row_hit;
    logic [PTR_W-1:0]  w_ptr_next;
    logic              w_wrap;
    logic [SEL_W-1:0]  w_rd_sel;
    logic [PTR_W-1:0]  w_last;
    logic              w_mode_ok;
    logic              w_sel_ok;
    logic              w_len_ok;
    logic              w_tab_we;
    logic              w_len_we;
    logic              w_err_set;

    // Active mode: scan downward so the lowest set bit is the one kept.
    always_comb begin
        w_am       = '0;
        w_mode_vld = 1'b0;
        for (int i = N_MODE - 1; i >= 0; i--) begin
            if (mode_i[i]) begin
                w_am       = MODE_W'(i);
                w_mode_vld = 1'b1;
            end
        end
    end

    // Idle counts as its own "mode" so entering or leaving idle restarts too.
    assign w_mode_chg = (w_mode_vld != r_mode_vld) ||
                        (w_mode_vld && (w_am != r_am));

    assign w_row_last = RC_W'(row_last_f(32'(pic_size_i), 32'(padding_i),
                                         32'(kernel_i)));
    assign w_row_hit  = ctrl_update_i && (r_rcnt == w_row_last);

    always_comb begin
        w_ptr_next = r_ptr;
        w_wrap     = 1'b0;
        if (ctrl_reset_i) begin
            w_ptr_next = '0;
        end else if (w_row_hit && row_rst_en_i[w_am]) begin
            w_ptr_next = '0;
        end else if (ctrl_update_i && (r_ptr >= w_last)) begin
            // >= rather than == so shrinking last below ptr still wraps.
            w_ptr_next = '0;
            w_wrap     = w_mode_vld;
        end else if (ctrl_update_i) begin
            w_ptr_next = r_ptr + PTR_W'(1);
        end
        if (!w_mode_vld || w_mode_chg) begin
            w_ptr_next = '0;
        end
    end

    // Each write is screened on its own; an illegal one is dropped and
    // latches the error flag.
    assign w_mode_ok = (32'(cfg_mode_i) < 32'(N_MODE));
    assign w_sel_ok  = (32'(cfg_data_i) < 32'(N_SEL));
    assign w_len_ok  = (32'(cfg_data_i) < 32'(SEQ_DEPTH));
    assign w_tab_we  = cfg_we_i     && w_mode_ok && w_sel_ok;
    assign w_len_we  = cfg_len_we_i && w_mode_ok && w_len_ok;
    assign w_err_set = (cfg_we_i     && !(w_mode_ok && w_sel_ok)) ||
                       (cfg_len_we_i && !(w_mode_ok && w_len_ok));

    mux_seq_table #(
        .N_MODE    (N_MODE),
        .SEQ_DEPTH (SEQ_DEPTH),
        .SEL_W     (SEL_W),
        .PTR_W     (PTR_W),
        .MODE_W    (MODE_W)
    ) u_table (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST   (SYS_RST),
        .wr_tab_en (w_tab_we),
        .wr_len_en (w_len_we),
        .wr_mode   (cfg_mode_i),
        .wr_addr   (cfg_addr_i),
        .wr_sel    (cfg_data_i[SEL_W-1:0]),
        .wr_last   (cfg_data_i[PTR_W-1:0]),
        .rd_mode   (w_am),
        .rd_ptr    (w_ptr_next),
        .rd_sel    (w_rd_sel),
        .rd_last   (w_last)
    );

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_ptr      <= '0;
            r_rcnt     <= '0;
            r_am       <= '0;
            r_mode_vld <= 1'b0;
            r_mux      <= '0;
            r_row_end  <= 1'b0;
            r_seq_wrap <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_next;
            r_am       <= w_am;
            r_mode_vld <= w_mode_vld;
            r_mux      <= w_mode_vld ? w_rd_sel : '0;
            r_row_end  <= w_row_hit && !ctrl_reset_i;
            r_seq_wrap <= w_wrap;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (ctrl_reset_i || w_row_hit) begin
                r_rcnt <= '0;
            end else if (ctrl_update_i) begin
                r_rcnt <= r_rcnt + RC_W'(1);
            end
        end
    end

    assign ctrl_mux_o = r_mux;
    assign row_end_o  = r_row_end;
    assign seq_wrap_o = r_seq_wrap;
    assign cfg_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_ctrl_seq
// Description : Self-checking bench for mux_ctrl_seq: directed scenarios with
//               literal expectations plus a randomized run compared every
//               cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_ctrl_seq;
    import mux_ctrl_pkg::*;

    logic       SYS_CLK = 1'b0;
    logic       SYS_RST;
    logic [3:0] mode_i;
    logic       ctrl_update_i;
    logic       ctrl_reset_i;
    logic [5:0] pic_size_i;
    logic [1:0] padding_i;
    logic [3:0] kernel_i;
    logic       cfg_we_i;
    logic       cfg_len_we_i;
    logic [1:0] cfg_mode_i;
    logic [3:0] cfg_addr_i;
    logic [3:0] cfg_data_i;
    logic [3:0] row_rst_en_i;
    logic [2:0] ctrl_mux_o;
    logic       row_end_o;
    logic       seq_wrap_o;
    logic       cfg_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    mux_ctrl_seq dut (
        .SYS_CLK      (SYS_CLK),
        .SYS_RST      (SYS_RST),
        .mode_i       (mode_i),
        .ctrl_update_i(ctrl_update_i),
        .ctrl_reset_i (ctrl_reset_i),
        .pic_size_i   (pic_size_i),
        .padding_i    (padding_i),
        .kernel_i     (kernel_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_len_we_i (cfg_len_we_i),
        .cfg_mode_i   (cfg_mode_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .row_rst_en_i (row_rst_en_i),
        .ctrl_mux_o   (ctrl_mux_o),
        .row_end_o    (row_end_o),
        .seq_wrap_o   (seq_wrap_o),
        .cfg_err_o    (cfg_err_o)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_tab [4][16];
    int  m_last [4];
    int  m_ptr, m_rcnt, m_prev;   // m_prev: previous active mode, -1 = idle
    int  e_mux, e_row, e_wrap, e_err;
    bit  m_vld = 1'b0;

    function automatic int low_bit(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    always @(posedge SYS_CLK) begin
        int am, rl, np;
        bit hit, wr;
        m_vld = 1'b1;
        if (SYS_RST) begin
            foreach (m_tab[a, b]) m_tab[a][b] = 0;
            foreach (m_last[a]) m_last[a] = 0;
            m_ptr = 0; m_rcnt = 0; m_prev = -1;
            e_mux = 0; e_row = 0; e_wrap = 0; e_err = 0;
        end else begin
            am  = low_bit(mode_i);
            rl  = int'(pic_size_i) + 2 * int'(padding_i) - int'(kernel_i);
            if (rl < 0) rl = 0;
            hit = ctrl_update_i && (m_rcnt == rl);
            np  = m_ptr;
            wr  = 1'b0;
            if (ctrl_reset_i) np = 0;
            else if (hit && am >= 0 && row_rst_en_i[am]) np = 0;
            else if (ctrl_update_i && am >= 0 && m_ptr >= m_last[am]) begin
                np = 0; wr = 1'b1;
            end else if (ctrl_update_i) np = (m_ptr + 1) % 16;
            if (am < 0 || am != m_prev) np = 0;
            e_mux  = (am < 0) ? 0 : m_tab[am][np];
            e_row  = (hit && !ctrl_reset_i) ? 1 : 0;
            e_wrap = wr ? 1 : 0;
            if (ctrl_reset_i || hit) m_rcnt = 0;
            else if (ctrl_update_i) m_rcnt = (m_rcnt + 1) % 256;
            if (cfg_we_i) begin
                if (cfg_data_i >= 6) e_err = 1;
                else m_tab[cfg_mode_i][cfg_addr_i] = int'(cfg_data_i);
            end
            if (cfg_len_we_i) m_last[cfg_mode_i] = int'(cfg_data_i);
            m_ptr  = np;
            m_prev = am;
        end
    end

    always @(negedge SYS_CLK) begin
        if (m_vld) begin
            chk("model_mux",  int'(ctrl_mux_o), e_mux);
            chk("model_row",  int'(row_end_o),  e_row);
            chk("model_wrap", int'(seq_wrap_o), e_wrap);
            chk("model_err",  int'(cfg_err_o),  e_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge SYS_CLK);
        #1;
        ctrl_update_i = 1'b0;
        ctrl_reset_i  = 1'b0;
        cfg_we_i      = 1'b0;
        cfg_len_we_i  = 1'b0;
    endtask

    task automatic wr_tab(input int m, input int a, input int d);
        cfg_we_i = 1'b1; cfg_mode_i = 2'(m); cfg_addr_i = 4'(a); cfg_data_i = 4'(d);
        cyc();
    endtask

    task automatic wr_len(input int m, input int d);
        cfg_len_we_i = 1'b1; cfg_mode_i = 2'(m); cfg_data_i = 4'(d);
        cyc();
    endtask

    task automatic upd();
        ctrl_update_i = 1'b1;
        cyc();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mux"},  int'(ctrl_mux_o), 0);
        chk({tag, "_row"},  int'(row_end_o),  0);
        chk({tag, "_wrap"}, int'(seq_wrap_o), 0);
        chk({tag, "_err"},  int'(cfg_err_o),  0);
    endtask

    initial begin
        SYS_RST = 1'b1; mode_i = '0; ctrl_update_i = 0; ctrl_reset_i = 0;
        pic_size_i = 6'd63; padding_i = 2'd0; kernel_i = 4'd1;
        cfg_we_i = 0; cfg_len_we_i = 0; cfg_mode_i = '0; cfg_addr_i = '0;
        cfg_data_i = '0; row_rst_en_i = '0;
        repeat (3) cyc();
        chk_zero("reset");
        SYS_RST = 1'b0;

        // Mode 0 pattern walk with wrap on update 12
        for (int i = 0; i < c_mode0_len; i++) wr_tab(0, i, c_mode0_pat[i]);
        wr_len(0, c_mode0_last);
        mode_i = 4'b0001;
        cyc();
        chk("m0_start", int'(ctrl_mux_o), 0);
        for (int k = 1; k <= 13; k++) begin
            upd();
            chk("m0_seq_mux",  int'(ctrl_mux_o), c_mode0_pat[k % 12]);
            chk("m0_seq_wrap", int'(seq_wrap_o), (k == 12) ? 1 : 0);
            chk("m0_seq_row",  int'(row_end_o),  0);
        end

        // Reset together with update at ptr=5
        repeat (4) upd();
        chk("m0_ptr5", int'(ctrl_mux_o), 5);
        ctrl_reset_i = 1'b1; ctrl_update_i = 1'b1;
        cyc();
        chk("rst_upd_mux",  int'(ctrl_mux_o), 0);
        chk("rst_upd_wrap", int'(seq_wrap_o), 0);
        chk("rst_upd_row",  int'(row_end_o),  0);
        upd();
        chk("after_rst_mux", int'(ctrl_mux_o), 1);

        // Illegal write colliding with an update, then a legal rewrite
        ctrl_update_i = 1'b1;
        wr_tab(0, 2, 7);
        chk("collide_mux", int'(ctrl_mux_o), 2);
        chk("collide_err", int'(cfg_err_o),  1);
        wr_tab(0, 2, 5);
        ctrl_reset_i = 1'b1;
        cyc();
        upd(); upd();
        chk("rewrite_mux", int'(ctrl_mux_o), 5);

        // Mode 1 with row-end pointer restart (row_last = 7)
        for (int i = 0; i < c_mode1_len; i++) wr_tab(1, i, c_mode1_pat[i]);
        wr_len(1, c_mode1_last);
        row_rst_en_i = 4'b0010;
        pic_size_i = 6'd8; padding_i = 2'd1; kernel_i = 4'd3;
        mode_i = 4'b0010; ctrl_reset_i = 1'b1;
        cyc();
        chk("m1_start", int'(ctrl_mux_o), 0);
        begin
            int exp_mux [8] = '{3, 4, 0, 3, 4, 0, 3, 0};
            for (int k = 1; k <= 8; k++) begin
                upd();
                chk("m1_mux",  int'(ctrl_mux_o), exp_mux[k-1]);
                chk("m1_row",  int'(row_end_o),  (k == 8) ? 1 : 0);
                chk("m1_wrap", int'(seq_wrap_o), (k == 3 || k == 6) ? 1 : 0);
            end
        end

        // Mode switch mid-sequence, then idle
        pic_size_i = 6'd63; padding_i = 2'd0; kernel_i = 4'd1;
        mode_i = 4'b0001;
        cyc();
        upd(); upd();
        chk("sw_m0_mux", int'(ctrl_mux_o), 5);
        mode_i = 4'b0010;
        cyc();
        chk("sw_m1_mux0", int'(ctrl_mux_o), 0);
        upd();
        chk("sw_m1_mux1", int'(ctrl_mux_o), 3);
        mode_i = 4'b0000;
        cyc();
        chk("idle_mux", int'(ctrl_mux_o), 0);
        upd();
        chk("idle_upd_mux", int'(ctrl_mux_o), 0);

        // Negative row_last clamps to 0: row end on every update
        pic_size_i = 6'd2; padding_i = 2'd0; kernel_i = 4'd3;
        mode_i = 4'b0001; ctrl_reset_i = 1'b1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            upd();
            chk("clamp_row", int'(row_end_o), 1);
        end
        row_rst_en_i = '0;

        // Randomized run against the model, with one mid-run reset
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                SYS_RST = 1'b1;
                cyc(); cyc();
                chk_zero("midrst");
                SYS_RST = 1'b0;
            end
            if ($urandom_range(99) < 4) begin
                mode_i = 4'($urandom_range(15));
            end else begin
                ctrl_update_i = ($urandom_range(99) < 70);
            end
            ctrl_reset_i = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 10) begin
                cfg_we_i   = 1'b1;
                cfg_mode_i = 2'($urandom_range(3));
                cfg_addr_i = 4'($urandom_range(15));
                cfg_data_i = ($urandom_range(99) < 5) ? 4'($urandom_range(7, 6))
                                                      : 4'($urandom_range(5));
            end else if ($urandom_range(99) < 5) begin
                cfg_len_we_i = 1'b1;
                cfg_mode_i   = 2'($urandom_range(3));
                cfg_data_i   = 4'($urandom_range(15));
            end
            if ($urandom_range(99) < 2) begin
                pic_size_i = 6'($urandom_range(20));
                padding_i  = 2'($urandom_range(3));
                kernel_i   = 4'($urandom_range(15));
            end
            if ($urandom_range(99) < 2) row_rst_en_i = 4'($urandom_range(15));
            cyc();
        end

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
